// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared opcodes, counter encodings and BTB entry type for the branch predictor
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest tag any BTB size can need (a 1-entry BTB keeps pc[31:2]);
  // narrower BTBs leave the upper tag bits at zero.
  localparam int TAG_W = 30;

  typedef struct packed {
    logic             valid;
    logic             is_jal;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  // 2-bit saturating counter step toward taken (11) or not-taken (00)
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped tagged branch target buffer, one read port and one write port
module bp_btb
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry,
  output btb_entry_t       wr_prev_entry
);

  localparam int DEPTH = 1 << IDX_W;

  btb_entry_t mem_q [DEPTH];
  btb_entry_t mem_d [DEPTH];

  // Both ports read the current contents, so a same-cycle write is not visible until the next cycle
  assign rd_entry      = mem_q[rd_idx];
  assign wr_prev_entry = mem_q[wr_idx];

  // Next-state of the array: a write replaces the whole entry, evicting any other tag at that index
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_entry;
    end
  end

  // Entry storage; reset clears every entry so all valid bits start low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - bimodal/gshare direction predictor with tagged BTB and statistics
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int PHT_IDX_W = 6,
  parameter int GHR_LEN   = 6,
  parameter int BTB_IDX_W = 4,
  parameter int MODE      = 1,
  parameter int STAT_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic              pred_btb_hit,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic [6:0]        update_opcode,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam int TAG_SH = BTB_IDX_W + 2;

  logic [1:0]           pht_q [PHT_N];
  logic [1:0]           pht_d [PHT_N];
  logic [GHR_LEN-1:0]   ghr_q, ghr_d;

  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [31:0]          pred_target_q, pred_target_d;
  logic                 pred_btb_hit_q, pred_btb_hit_d;
  logic                 mispredict_q, mispredict_d;
  logic [STAT_W-1:0]    stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0]    stat_mispredicts_q, stat_mispredicts_d;

  logic [BTB_IDX_W-1:0] l_bidx, u_bidx;
  logic [TAG_W-1:0]     l_tag, u_tag;
  logic [PHT_IDX_W-1:0] l_pidx, u_pidx;
  btb_entry_t           l_entry, u_entry, w_entry;
  logic                 w_en;
  logic                 l_hit, u_hit, u_tgt_bad, upd_br, upd_jal;
  logic                 unused_bits;

  // PC word index, folded with the global history in gshare mode
  function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [31:0] pc,
                                                     input logic [GHR_LEN-1:0] ghr);
    logic [PHT_IDX_W-1:0] idx;
    idx = pc[PHT_IDX_W+1:2];
    if (MODE == 1) begin
      idx = idx ^ PHT_IDX_W'(ghr);
    end
    return idx;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign l_bidx      = lookup_pc[BTB_IDX_W+1:2];
  assign u_bidx      = update_pc[BTB_IDX_W+1:2];
  assign l_tag       = TAG_W'(lookup_pc >> TAG_SH);
  assign u_tag       = TAG_W'(update_pc >> TAG_SH);
  assign l_pidx      = pht_index(lookup_pc, ghr_q);
  assign u_pidx      = pht_index(update_pc, ghr_q);
  assign unused_bits = ^{update_pc[1:0], u_entry.is_jal};

  bp_btb #(.IDX_W(BTB_IDX_W)) u_btb (
    .clk          (CLK),
    .rst          (RST),
    .rd_idx       (l_bidx),
    .rd_entry     (l_entry),
    .wr_en        (w_en),
    .wr_idx       (u_bidx),
    .wr_entry     (w_entry),
    .wr_prev_entry(u_entry)
  );

  // Lookup: form a prediction from pre-update state; idle cycles keep the last prediction
  always_comb begin
    l_hit          = l_entry.valid && (l_entry.tag == l_tag);
    pred_valid_d   = lookup_valid;
    pred_taken_d   = pred_taken_q;
    pred_target_d  = pred_target_q;
    pred_btb_hit_d = pred_btb_hit_q;
    if (lookup_valid) begin
      pred_btb_hit_d = l_hit;
      pred_taken_d   = l_hit && (l_entry.is_jal || pht_q[l_pidx][1]);
      pred_target_d  = pred_taken_d ? l_entry.target : lookup_pc + 32'd4;
    end
  end

  // Update: judge the resolved instruction against current state, then train PHT, GHR and BTB
  always_comb begin
    upd_br             = update_valid && (update_opcode == OPC_BRANCH);
    upd_jal            = update_valid && (update_opcode == OPC_JAL);
    u_hit              = u_entry.valid && (u_entry.tag == u_tag);
    u_tgt_bad          = u_hit && (u_entry.target != update_target);
    pht_d              = pht_q;
    ghr_d              = ghr_q;
    w_en               = 1'b0;
    w_entry            = '{valid: 1'b1, is_jal: upd_jal, tag: u_tag, target: update_target};
    mispredict_d       = 1'b0;
    stat_branches_d    = stat_branches_q;
    if (upd_br) begin
      mispredict_d    = ((pht_q[u_pidx][1] && u_hit) != update_taken) || (update_taken && u_tgt_bad);
      pht_d[u_pidx]   = sat2_next(pht_q[u_pidx], update_taken);
      ghr_d           = GHR_LEN'({ghr_q, update_taken});
      w_en            = update_taken;
      stat_branches_d = sat_inc(stat_branches_q);
    end else if (upd_jal) begin
      mispredict_d = !u_hit || u_tgt_bad;
      w_en         = 1'b1;
    end
    stat_mispredicts_d = mispredict_d ? sat_inc(stat_mispredicts_q) : stat_mispredicts_q;
  end

  // Predictor tables: counters start weakly not-taken, history starts empty
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= WNT;
      end
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

  // Registered prediction, mispredict pulse and statistics
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      pred_target_q      <= '0;
      pred_btb_hit_q     <= 1'b0;
      mispredict_q       <= 1'b0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      pred_target_q      <= pred_target_d;
      pred_btb_hit_q     <= pred_btb_hit_d;
      mispredict_q       <= mispredict_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign pred_btb_hit     = pred_btb_hit_q;
  assign mispredict       = mispredict_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - bimodal and gshare instances against a behavioural predictor model
module tb_branch_predictor_gshare;

  localparam int SW   = 5;
  localparam int SMAX = (1 << SW) - 1;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [6:0]  update_opcode = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;

  logic          pv0, pt0, hit0, mis0, pv1, pt1, hit1, mis1;
  logic [31:0]   tg0, tg1;
  logic [SW-1:0] sb0, sm0, sb1, sm1;

  logic          o_pv [2], o_pt [2], o_hit [2], o_mis [2];
  logic [31:0]   o_tg [2];
  logic [SW-1:0] o_sb [2], o_sm [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.PHT_IDX_W(6), .GHR_LEN(6), .BTB_IDX_W(4), .MODE(0), .STAT_W(SW)) u_bi (
    .CLK(clk), .RST(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv0), .pred_taken(pt0), .pred_target(tg0), .pred_btb_hit(hit0),
    .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
    .update_taken(update_taken), .update_target(update_target),
    .mispredict(mis0), .stat_branches(sb0), .stat_mispredicts(sm0));

  branch_predictor_gshare #(.PHT_IDX_W(6), .GHR_LEN(2), .BTB_IDX_W(4), .MODE(1), .STAT_W(SW)) u_gs (
    .CLK(clk), .RST(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv1), .pred_taken(pt1), .pred_target(tg1), .pred_btb_hit(hit1),
    .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
    .update_taken(update_taken), .update_target(update_target),
    .mispredict(mis1), .stat_branches(sb1), .stat_mispredicts(sm1));

  always_comb begin
    o_pv[0] = pv0;  o_pt[0] = pt0;  o_hit[0] = hit0; o_mis[0] = mis0;
    o_tg[0] = tg0;  o_sb[0] = sb0;  o_sm[0] = sm0;
    o_pv[1] = pv1;  o_pt[1] = pt1;  o_hit[1] = hit1; o_mis[1] = mis1;
    o_tg[1] = tg1;  o_sb[1] = sb1;  o_sm[1] = sm1;
  end

  // Reference model: instance 0 is bimodal with 6 history bits, instance 1 is gshare with 2
  int          m_pht [2][64];
  int          m_ghr [2];
  bit          m_bv  [2][16];
  bit          m_bj  [2][16];
  logic [31:0] m_tag [2][16];
  logic [31:0] m_tgt [2][16];
  int          m_sb  [2];
  int          m_sm  [2];
  bit          e_pv [2], e_pt [2], e_hit [2], e_mis [2];
  logic [31:0] e_tg [2];

  function automatic int pidx_of(input int k, input logic [31:0] pc, input int ghr);
    int base;
    base = int'((pc >> 2) & 32'd63);
    return (k == 1) ? (base ^ ghr) : base;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) m_pht[k][i] = 1;
      for (int i = 0; i < 16; i++) m_bv[k][i] = 1'b0;
      m_ghr[k] = 0; m_sb[k] = 0; m_sm[k] = 0;
      e_pv[k] = 0; e_pt[k] = 0; e_hit[k] = 0; e_mis[k] = 0; e_tg[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    int li, bi, ui, ub, glen;
    bit h, uh, ptk, mis;
    logic [31:0] utag;
    glen = (k == 1) ? 2 : 6;
    if (lookup_valid) begin
      li = pidx_of(k, lookup_pc, m_ghr[k]);
      bi = int'((lookup_pc >> 2) & 32'd15);
      h  = m_bv[k][bi] && (m_tag[k][bi] == (lookup_pc >> 6));
      e_pv[k]  = 1'b1;
      e_hit[k] = h;
      e_pt[k]  = h && (m_bj[k][bi] || m_pht[k][li] >= 2);
      e_tg[k]  = e_pt[k] ? m_tgt[k][bi] : lookup_pc + 32'd4;
    end else begin
      e_pv[k] = 1'b0;
    end
    mis  = 1'b0;
    ub   = int'((update_pc >> 2) & 32'd15);
    utag = update_pc >> 6;
    uh   = m_bv[k][ub] && (m_tag[k][ub] == utag);
    if (update_valid && update_opcode == BR) begin
      ui  = pidx_of(k, update_pc, m_ghr[k]);
      ptk = uh && (m_pht[k][ui] >= 2);
      mis = (ptk != update_taken) || (update_taken && uh && m_tgt[k][ub] != update_target);
      if (update_taken) m_pht[k][ui] = (m_pht[k][ui] < 3) ? m_pht[k][ui] + 1 : 3;
      else              m_pht[k][ui] = (m_pht[k][ui] > 0) ? m_pht[k][ui] - 1 : 0;
      m_ghr[k] = ((m_ghr[k] << 1) | int'(update_taken)) & ((1 << glen) - 1);
      if (update_taken) begin
        m_bv[k][ub] = 1'b1; m_bj[k][ub] = 1'b0; m_tag[k][ub] = utag; m_tgt[k][ub] = update_target;
      end
      if (m_sb[k] < SMAX) m_sb[k]++;
    end else if (update_valid && update_opcode == JAL) begin
      mis = !uh || (m_tgt[k][ub] != update_target);
      m_bv[k][ub] = 1'b1; m_bj[k][ub] = 1'b1; m_tag[k][ub] = utag; m_tgt[k][ub] = update_target;
    end
    e_mis[k] = mis;
    if (mis && m_sm[k] < SMAX) m_sm[k]++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          check("pred_valid", k, 32'(o_pv[k]), 32'(e_pv[k]));
          check("pred_taken", k, 32'(o_pt[k]), 32'(e_pt[k]));
          check("pred_target", k, o_tg[k], e_tg[k]);
          check("pred_btb_hit", k, 32'(o_hit[k]), 32'(e_hit[k]));
          check("mispredict", k, 32'(o_mis[k]), 32'(e_mis[k]));
          check("stat_branches", k, 32'(o_sb[k]), 32'(m_sb[k]));
          check("stat_mispredicts", k, 32'(o_sm[k]), 32'(m_sm[k]));
        end
      end
    end
  end

  task automatic idle();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                     input logic [6:0] opc, input bit ut, input logic [31:0] utg);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_opcode = opc;
    update_taken = ut; update_target = utg;
    @(posedge clk);
    #1;
  endtask

  // Reset is raised between clock edges and the outputs are examined before any edge arrives
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pred_valid", 0, 32'(pv0), 0);
    check("rst_pred_taken", 0, 32'(pt0), 0);
    check("rst_pred_target", 0, tg0, 0);
    check("rst_pred_btb_hit", 0, 32'(hit0), 0);
    check("rst_mispredict", 0, 32'(mis0), 0);
    check("rst_stat_branches", 0, 32'(sb0), 0);
    check("rst_stat_mispredicts", 0, 32'(sm0), 0);
    check("rst_pred_target", 1, tg1, 0);
    check("rst_stat_mispredicts", 1, 32'(sm1), 0);
    idle();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic rand_drive();
    int r;
    lookup_valid  = ($urandom_range(0, 3) != 0);
    lookup_pc     = rand_pc();
    update_valid  = ($urandom_range(0, 3) != 0);
    update_pc     = rand_pc();
    r             = int'($urandom_range(0, 9));
    update_opcode = (r < 5) ? BR : (r < 7) ? JAL : (r < 8) ? JALR : 7'b0110011;
    update_taken  = 1'($urandom_range(0, 1));
    update_target = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // cold lookup
    cyc(1, 32'h100, 0, 0, BR, 0, 0);
    check("t1_valid", 0, 32'(pv0), 1);
    check("t1_taken", 0, 32'(pt0), 0);
    check("t1_target", 0, tg0, 32'h104);
    check("t1_hit", 0, 32'(hit0), 0);
    cyc(0, 32'h300, 0, 0, BR, 0, 0);
    check("t1_idle_valid", 0, 32'(pv0), 0);
    check("t1_hold_target", 0, tg0, 32'h104);

    // bimodal training on a taken branch
    do_reset();
    cyc(0, 0, 1, 32'h100, BR, 1, 32'h80);
    check("t2_first_mis", 0, 32'(mis0), 1);
    cyc(0, 0, 1, 32'h100, BR, 1, 32'h80);
    check("t2_second_mis", 0, 32'(mis0), 0);
    cyc(1, 32'h100, 0, 0, BR, 0, 0);
    check("t2_taken", 0, 32'(pt0), 1);
    check("t2_target", 0, tg0, 32'h80);
    check("t2_branches", 0, 32'(sb0), 2);
    check("t2_mispredicts", 0, 32'(sm0), 1);

    // JAL and JALR
    do_reset();
    cyc(0, 0, 1, 32'h200, JAL, 1, 32'h400);
    check("t3_jal_mis", 1, 32'(mis1), 1);
    cyc(1, 32'h200, 0, 0, BR, 0, 0);
    check("t3_jal_taken", 1, 32'(pt1), 1);
    check("t3_jal_target", 0, tg0, 32'h400);
    check("t3_branches", 0, 32'(sb0), 0);
    cyc(0, 0, 1, 32'h200, JALR, 1, 32'h999);
    check("t3_jalr_mis", 0, 32'(mis0), 0);
    cyc(1, 32'h200, 0, 0, BR, 0, 0);
    check("t3_jalr_target", 0, tg0, 32'h400);

    // gshare learns an alternating branch
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 32'h40, BR, (i % 2) == 0, 32'h20);
      if (i >= 8) check("t4_gshare_mis", 1, 32'(mis1), 0);
    end

    // read-before-write and BTB eviction
    do_reset();
    cyc(1, 32'h100, 1, 32'h100, BR, 1, 32'h80);
    check("t5_same_cycle_taken", 0, 32'(pt0), 0);
    check("t5_same_cycle_hit", 0, 32'(hit0), 0);
    cyc(1, 32'h100, 0, 0, BR, 0, 0);
    check("t5_next_taken", 0, 32'(pt0), 1);
    check("t5_next_target", 0, tg0, 32'h80);
    cyc(0, 0, 1, 32'h140, BR, 1, 32'h90);
    cyc(1, 32'h100, 0, 0, BR, 0, 0);
    check("t5_evicted_hit", 0, 32'(hit0), 0);
    check("t5_evicted_target", 0, tg0, 32'h104);

    // mispredict counter saturation
    do_reset();
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 32'h300, JAL, 1, 32'h1000 + 32'(i) * 32'd4);
    check("t6_near_max", 0, 32'(sm0), SMAX - 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h300, JAL, 1, 32'h2000 + 32'(i) * 32'd4);
    check("t6_saturated", 0, 32'(sm0), SMAX);
    check("t6_still_pulses", 0, 32'(mis0), 1);

    // randomized traffic with an asynchronous reset in the middle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rand_drive();
        do_reset();
      end
      rand_drive();
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised dynamic branch predictor for the OTTER MCU. It is the successor to the current passive Branch_Predictor monitor and actually produces predictions.
- Pattern history table (PHT) of 2-bit saturating counters, indexed either bimodally or gshare-style (PC XOR global history).
- Direct-mapped tagged branch target buffer (BTB).
- Saturating statistics counters.
- Sits beside PC/PC_MUX: looked up with CIS at fetch, trained when CU_FSM resolves a branch or JAL.

Parameters:
PHT_IDX_W, 6, log2 of PHT entries (64).
GHR_LEN, 6, global history length in bits; must satisfy 1 <= GHR_LEN <= PHT_IDX_W.
BTB_IDX_W, 4, log2 of BTB entries (16).
MODE, 1, 0 = bimodal (index = PC only), 1 = gshare.
STAT_W, 32, width of statistics counters.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
lookup_valid  in  1  request a prediction for lookup_pc.
lookup_pc  in  32  fetch PC (CIS).
pred_valid  out  1  prediction outputs are valid this cycle.
pred_taken  out  1  predicted direction.
pred_target  out  32  predicted target; equals lookup_pc+4 when not taken or on BTB miss.
pred_btb_hit  out  1  BTB tag match for the looked-up PC.
update_valid  in  1  resolved control-transfer instruction.
update_pc  in  32  PC of the resolved instruction.
update_opcode  in  7  ir[6:0] of the resolved instruction.
update_taken  in  1  actual direction.
update_target  in  32  actual target (branch or jal from Target_Gen).
mispredict  out  1  registered; 1 for one cycle after a mispredicted update.
stat_branches  out  STAT_W  count of conditional branches trained.
stat_mispredicts  out  STAT_W  count of mispredicts.

Behaviour:
Reset, asynchronous:
- pred_valid=0, pred_taken=0, pred_target=0, pred_btb_hit=0, mispredict=0.
- Both stat counters = 0, GHR = 0.
- All PHT entries = 2'b01 (weakly not-taken); all BTB valid bits = 0.
- Reset asserted mid-operation discards any pending lookup or update.

Index and tag computation:
- pidx = lookup_pc[PHT_IDX_W+1:2], XORed with the zero-extended GHR when MODE=1.
- bidx = pc[BTB_IDX_W+1:2].
- tag = pc[31:BTB_IDX_W+2].

Lookup (1-cycle latency):
- If lookup_valid is high in cycle N, outputs are registered and valid in cycle N+1 with pred_valid=1.
- Otherwise pred_valid=0 and the other pred outputs hold their previous values.
- pred_btb_hit = valid[bidx] && tag matches.
- pred_taken = pred_btb_hit && (entry is JAL || PHT[pidx][1]).
- pred_target = BTB target if pred_taken, else lookup_pc+4 (32-bit wrap).

Update (takes effect at the CLK edge):
- Conditional branch (opcode 7'b1100011):
  - Compute uidx with the current GHR.
  - Counter saturates: increments toward 11 if taken, decrements toward 00 if not.
  - GHR <= {GHR[GHR_LEN-2:0], update_taken}.
  - If taken, write BTB entry {valid=1, tag, target, is_jal=0}.
  - stat_branches increments.
- JAL (opcode 7'b1101111): write BTB entry with is_jal=1. PHT, GHR and stat_branches are untouched.
- Any other opcode, including JALR: the update is ignored entirely.
- Misprediction check, evaluated against pre-update state:
  - branch: (PHT[uidx][1] && hit) != update_taken, or (taken && hit && stored target != update_target);
  - JAL: BTB miss or target mismatch.
- On a misprediction, mispredict=1 in the next cycle and stat_mispredicts increments.
- Both stat counters saturate at all-ones and do not wrap.

Simultaneous events:
- Lookup and update in the same cycle: the lookup reads pre-update PHT, BTB and GHR state (read-before-write).
- BTB conflict: a new tag overwrites the existing entry at that index; there is no associativity.

Decomposition:
- Package bp_pkg holds:
  - opcode constants OPC_BRANCH=7'b1100011 and OPC_JAL=7'b1101111;
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - typedef btb_entry_t {valid, is_jal, tag, target};
  - a function sat2_next(cnt, taken).
- One sub-module, bp_btb: the direct-mapped tagged target array with one read port and one write port.

Test Plan:
1. Reset, then lookup_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104, pred_btb_hit=0; stats 0.
2. MODE=0: update branch pc=0x100 taken, target=0x80, twice -> first update gives mispredict=1 (BTB miss) and counter 10; second gives mispredict=0 and counter 11. Lookup 0x100 -> pred_taken=1, pred_target=0x80. stat_branches=2, stat_mispredicts=1.
3. JAL update pc=0x200, target=0x400 -> lookup 0x200 gives pred_taken=1, pred_target=0x400; GHR and stat_branches unchanged. JALR update (opcode 1100111) -> no state change, mispredict=0.
4. MODE=1, GHR_LEN=2: alternating T/NT at pc=0x40 for 16 updates -> after warm-up, the last 8 updates give mispredict=0 (history separates the two patterns).
5. Same-cycle lookup and update on pc=0x100 with counter at 01, taken -> pred_taken=0 (old state); lookup on the following cycle returns the updated state. BTB aliasing: pc=0x100 then pc=0x140 with BTB_IDX_W=4 -> 0x100 is evicted, pred_btb_hit=0.
6. Force stat_mispredicts to all-ones minus 1, then 3 mispredicts -> counter holds at all-ones. Assert RST mid-sequence -> all outputs and tables return to reset values immediately (asynchronously).
